// File: rtl/ship_ctrl_pkg.sv
// Shared definitions for the ship movement controller: FSM state encoding,
// step direction encoding, default repeat timing and a small helper.
package ship_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DELAY   = 2'd2,
        REPEAT  = 2'd3
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int unsigned DEF_REPEAT_DELAY  = 15;
    localparam int unsigned DEF_REPEAT_PERIOD = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for one debounced button level: keeps the previous
// sample in a register and flags cycles where the level goes 0 -> 1.
module button_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    // Previous-sample register, cleared by asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/ship_move_ctrl.sv
// Ship movement controller: turns debounced left/right button levels into
// one-cycle, frame-paced step pulses with press latching, hold-to-repeat and
// opposing-button arbitration.
// Auto-repeat is enabled by defining SHIP_MOVE_CTRL_AUTOREPEAT_EN; without it
// a held button yields exactly one step per press.
module ship_move_ctrl
    import ship_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_frame_tick,
    input  logic i_left_debounced,
    input  logic i_right_debounced,
    output logic o_left_step,
    output logic o_right_step,
    output logic o_busy
);

    localparam int unsigned CNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             lstep_q, lstep_d;
    logic             rstep_q, rstep_d;
    logic             busy_q, busy_d;
    logic             armed_q;

    logic l_rise, r_rise;
    logic held, both;

    button_edge u_left_edge (
        .clk_i   (i_clk_25MHz),
        .rst_i   (i_reset),
        .level_i (i_left_debounced),
        .rise_o  (l_rise)
    );

    button_edge u_right_edge (
        .clk_i   (i_clk_25MHz),
        .rst_i   (i_reset),
        .level_i (i_right_debounced),
        .rise_o  (r_rise)
    );

    assign held = (dir_q == DIR_LEFT) ? i_left_debounced : i_right_debounced;
    assign both = i_left_debounced & i_right_debounced;

    // Next-state, counter and step-pulse decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        lstep_d = 1'b0;
        rstep_d = 1'b0;

        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // The previous-sample registers reset to 0, so a button
                    // held through reset would look like a press on the first
                    // edge afterwards; armed_q masks that one edge.
                    if (armed_q) begin
                        if (l_rise && !i_right_debounced) begin
                            state_d = PENDING;
                            dir_d   = DIR_LEFT;
                        end else if (r_rise && !i_left_debounced) begin
                            state_d = PENDING;
                            dir_d   = DIR_RIGHT;
                        end
                    end
                end
                PENDING: begin
                    if (i_frame_tick) begin
                        lstep_d = (dir_q == DIR_LEFT);
                        rstep_d = (dir_q == DIR_RIGHT);
                        cnt_d   = CNT_W'(REPEAT_DELAY);
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (!held || both) begin
                        state_d = IDLE;
                    end else if (i_frame_tick) begin
`ifdef SHIP_MOVE_CTRL_AUTOREPEAT_EN
                        if (cnt_q == CNT_W'(1)) begin
                            lstep_d = (dir_q == DIR_LEFT);
                            rstep_d = (dir_q == DIR_RIGHT);
                            cnt_d   = CNT_W'(REPEAT_PERIOD);
                            state_d = REPEAT;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
`else
                        state_d = DELAY;
`endif
                    end
                end
                REPEAT: begin
                    if (!held || both) begin
                        state_d = IDLE;
                    end else if (i_frame_tick) begin
`ifdef SHIP_MOVE_CTRL_AUTOREPEAT_EN
                        if (cnt_q == CNT_W'(1)) begin
                            lstep_d = (dir_q == DIR_LEFT);
                            rstep_d = (dir_q == DIR_RIGHT);
                            cnt_d   = CNT_W'(REPEAT_PERIOD);
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State, counter, direction and registered outputs.
    always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            lstep_q <= 1'b0;
            rstep_q <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            lstep_q <= lstep_d;
            rstep_q <= rstep_d;
            busy_q  <= busy_d;
            armed_q <= 1'b1;
        end
    end

    assign o_left_step  = lstep_q;
    assign o_right_step = rstep_q;
    assign o_busy       = busy_q;

endmodule
